// File: rtl/branch_resolve_unit.sv
// In-order branch resolution queue: holds predicted branches until execute
// resolves them, emits predictor training updates and flushes on mispredict.
module branch_resolve_unit #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pred_valid,
  input  logic [7:0]               pred_index,
  input  logic                     pred_taken,
  output logic                     pred_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  output logic                     res_ready,
  output logic                     upd_valid,
  output logic [7:0]               upd_index,
  output logic                     upd_taken,
  output logic                     mispredict,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         mispredict_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [7:0] idx;
    logic       pred;
  } entry_t;

  entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               upd_valid_q, upd_valid_d;
  logic [7:0]         upd_index_q, upd_index_d;
  logic               upd_taken_q, upd_taken_d;
  logic               mis_q, mis_d;
  logic [CNT_W-1:0]   mcnt_q, mcnt_d;

  logic   enq, deq, mis;
  entry_t head;

  assign pred_ready = (cnt_q != FULL);
  assign res_ready  = (cnt_q != '0);
  assign head       = mem_q[rptr_q];
  assign enq        = pred_valid && pred_ready;
  assign deq        = res_valid && res_ready;
  assign mis        = deq && (res_taken != head.pred);

  always_comb begin
    mem_d       = mem_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    cnt_d       = cnt_q;
    upd_valid_d = deq;
    upd_index_d = upd_index_q;
    upd_taken_d = upd_taken_q;
    mis_d       = mis;
    mcnt_d      = mcnt_q;

    if (deq) begin
      upd_index_d = head.idx;
      upd_taken_d = res_taken;
      rptr_d      = rptr_q + PW'(1);
    end

    if (mis) begin
      // Flush everything younger and drop any same-edge enqueue.
      rptr_d = wptr_q;
      cnt_d  = '0;
      if (mcnt_q != '1) mcnt_d = mcnt_q + CNT_W'(1);
    end else begin
      if (enq) begin
        mem_d[wptr_q] = entry_t'{idx: pred_index, pred: pred_taken};
        wptr_d        = wptr_q + PW'(1);
      end
      cnt_d = cnt_q + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q       <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      upd_valid_q <= 1'b0;
      upd_index_q <= '0;
      upd_taken_q <= 1'b0;
      mis_q       <= 1'b0;
      mcnt_q      <= '0;
    end else begin
      mem_q       <= mem_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      upd_valid_q <= upd_valid_d;
      upd_index_q <= upd_index_d;
      upd_taken_q <= upd_taken_d;
      mis_q       <= mis_d;
      mcnt_q      <= mcnt_d;
    end
  end

  assign upd_valid        = upd_valid_q;
  assign upd_index        = upd_index_q;
  assign upd_taken        = upd_taken_q;
  assign mispredict       = mis_q;
  assign occupancy        = cnt_q;
  assign mispredict_count = mcnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus randomized traffic
// against a queue-based reference model; a CNT_W=2 copy checks saturation.
module tb_branch_resolve_unit;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       pred_valid, pred_taken, res_valid, res_taken;
  logic [7:0] pred_index;
  logic       pred_ready, res_ready, upd_valid, upd_taken, mispredict;
  logic [7:0] upd_index;
  logic [2:0] occupancy;
  logic [15:0] mcount;
  logic       pred_ready2, res_ready2, upd_valid2, upd_taken2, mispredict2;
  logic [7:0] upd_index2;
  logic [2:0] occupancy2;
  logic [1:0] mcount2;

  int checks = 0;
  int fails  = 0;

  // reference model state
  logic [8:0] mq[$];
  bit         e_uv, e_ut, e_mis;
  logic [7:0] e_ui;
  int         mis_total;

  always #5 clk = ~clk;

  branch_resolve_unit #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .pred_valid(pred_valid), .pred_index(pred_index), .pred_taken(pred_taken),
    .pred_ready(pred_ready), .res_valid(res_valid), .res_taken(res_taken),
    .res_ready(res_ready), .upd_valid(upd_valid), .upd_index(upd_index),
    .upd_taken(upd_taken), .mispredict(mispredict), .occupancy(occupancy),
    .mispredict_count(mcount)
  );

  branch_resolve_unit #(.DEPTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .pred_valid(pred_valid), .pred_index(pred_index), .pred_taken(pred_taken),
    .pred_ready(pred_ready2), .res_valid(res_valid), .res_taken(res_taken),
    .res_ready(res_ready2), .upd_valid(upd_valid2), .upd_index(upd_index2),
    .upd_taken(upd_taken2), .mispredict(mispredict2), .occupancy(occupancy2),
    .mispredict_count(mcount2)
  );

  task automatic model_reset();
    mq.delete();
    e_uv = 0; e_ut = 0; e_mis = 0; e_ui = 8'h00; mis_total = 0;
  endtask

  // Drive one cycle from a negedge, advance the model at the posedge,
  // and return at the following negedge with inputs idle.
  task automatic step(input bit pv, input logic [7:0] pi, input bit pt,
                      input bit rv, input bit rt);
    bit full, dq, en;
    logic [8:0] hd;
    pred_valid = pv; pred_index = pi; pred_taken = pt;
    res_valid = rv; res_taken = rt;
    @(posedge clk);
    full = (mq.size() == 4);
    dq   = rv && (mq.size() > 0);
    en   = pv && !full;
    e_uv = dq; e_mis = 0;
    if (dq) begin
      hd = mq.pop_front();
      e_ui = hd[8:1]; e_ut = rt;
      if (rt != hd[0]) begin
        e_mis = 1; mis_total++; mq.delete(); en = 0;
      end
    end
    if (en) mq.push_back({pi, pt});
    @(negedge clk);
    pred_valid = 0; res_valid = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; pred_valid = 0; pred_index = 0; pred_taken = 0;
    res_valid = 0; res_taken = 0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++; if (occupancy !== 3'd0) begin fails++; $display("FAIL reset_occ: got %0d exp 0", occupancy); end
    checks++; if ({pred_ready, res_ready} !== 2'b10) begin fails++; $display("FAIL reset_rdy: got %b exp 10", {pred_ready, res_ready}); end
    checks++; if ({upd_valid, upd_index, upd_taken, mispredict} !== 11'd0) begin fails++; $display("FAIL reset_upd: got %h exp 0", {upd_valid, upd_index, upd_taken, mispredict}); end
    checks++; if (mcount !== 16'd0) begin fails++; $display("FAIL reset_cnt: got %0d exp 0", mcount); end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_training();
    step(1, 8'h10, 1, 0, 0);
    step(1, 8'h20, 0, 0, 0);
    checks++; if (occupancy !== 3'd2) begin fails++; $display("FAIL train_occ: got %0d exp 2", occupancy); end
    step(0, 8'h00, 0, 1, 1);
    checks++; if ({upd_valid, upd_index, upd_taken, mispredict} !== {1'b1, 8'h10, 1'b1, 1'b0}) begin fails++; $display("FAIL train_upd0: got %h exp %h", {upd_valid, upd_index, upd_taken, mispredict}, {1'b1, 8'h10, 1'b1, 1'b0}); end
    step(0, 8'h00, 0, 1, 0);
    checks++; if ({upd_valid, upd_index, upd_taken, mispredict} !== {1'b1, 8'h20, 1'b0, 1'b0}) begin fails++; $display("FAIL train_upd1: got %h exp %h", {upd_valid, upd_index, upd_taken, mispredict}, {1'b1, 8'h20, 1'b0, 1'b0}); end
    step(0, 8'h00, 0, 0, 0);
    checks++; if ({upd_valid, upd_index} !== {1'b0, 8'h20}) begin fails++; $display("FAIL train_hold: got %h exp 020", {upd_valid, upd_index}); end
    checks++; if (mcount !== 16'd0) begin fails++; $display("FAIL train_cnt: got %0d exp 0", mcount); end
  endtask

  task automatic test_flush();
    step(1, 8'h05, 1, 0, 0);
    step(1, 8'h06, 1, 0, 0);
    step(1, 8'h07, 0, 0, 0);
    step(0, 8'h00, 0, 1, 0);
    checks++; if ({upd_valid, upd_index, upd_taken} !== {1'b1, 8'h05, 1'b0}) begin fails++; $display("FAIL flush_upd: got %h exp %h", {upd_valid, upd_index, upd_taken}, {1'b1, 8'h05, 1'b0}); end
    checks++; if (mispredict !== 1'b1) begin fails++; $display("FAIL flush_mis: got %b exp 1", mispredict); end
    checks++; if ({occupancy, res_ready} !== {3'd0, 1'b0}) begin fails++; $display("FAIL flush_occ: got %h exp 0", {occupancy, res_ready}); end
    checks++; if (mcount !== 16'd1 || mcount2 !== 2'd1) begin fails++; $display("FAIL flush_cnt: got %0d/%0d exp 1/1", mcount, mcount2); end
    step(0, 8'h00, 0, 0, 0);
    checks++; if (mispredict !== 1'b0) begin fails++; $display("FAIL flush_pulse: got %b exp 0", mispredict); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) step(1, 8'h40 + 8'(i), i[0], 0, 0);
    checks++; if ({pred_ready, occupancy} !== {1'b0, 3'd4}) begin fails++; $display("FAIL full_rdy: got %h exp 4", {pred_ready, occupancy}); end
    step(1, 8'hEE, 0, 0, 0);
    checks++; if (occupancy !== 3'd4) begin fails++; $display("FAIL full_drop: got %0d exp 4", occupancy); end
    step(0, 8'h00, 0, 1, 0);
    checks++; if ({pred_ready, occupancy} !== {1'b1, 3'd3}) begin fails++; $display("FAIL full_free: got %h exp b", {pred_ready, occupancy}); end
    for (int i = 1; i < 4; i++) begin
      step(0, 8'h00, 0, 1, i[0]);
      checks++; if ({upd_index, mispredict} !== {8'h40 + 8'(i), 1'b0}) begin fails++; $display("FAIL full_order%0d: got %h exp %h", i, {upd_index, mispredict}, {8'h40 + 8'(i), 1'b0}); end
    end
  endtask

  task automatic test_simultaneous();
    step(1, 8'h30, 1, 0, 0);
    step(1, 8'h31, 0, 0, 0);
    step(1, 8'h32, 1, 1, 1);
    checks++; if ({occupancy, upd_index, mispredict} !== {3'd2, 8'h30, 1'b0}) begin fails++; $display("FAIL sim_ok: got %h exp %h", {occupancy, upd_index, mispredict}, {3'd2, 8'h30, 1'b0}); end
    step(1, 8'h33, 1, 1, 1);
    checks++; if ({occupancy, upd_index, mispredict} !== {3'd0, 8'h31, 1'b1}) begin fails++; $display("FAIL sim_mis: got %h exp %h", {occupancy, upd_index, mispredict}, {3'd0, 8'h31, 1'b1}); end
  endtask

  task automatic test_saturation_wrap();
    for (int k = 0; k < 3; k++) begin
      step(1, 8'h90 + 8'(k), 1, 0, 0);
      step(0, 8'h00, 0, 1, 0);
    end
    checks++; if (mcount2 !== 2'd3) begin fails++; $display("FAIL sat_cnt2: got %0d exp 3", mcount2); end
    checks++; if (mcount !== 16'd5) begin fails++; $display("FAIL sat_cnt16: got %0d exp 5", mcount); end
    step(1, 8'h80, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      step(1, 8'h80 + 8'(i), i[0], 1, ~i[0]);
      checks++; if ({upd_index, occupancy, mispredict} !== {8'h80 + 8'(i - 1), 3'd1, 1'b0}) begin fails++; $display("FAIL wrap%0d: got %h exp %h", i, {upd_index, occupancy, mispredict}, {8'h80 + 8'(i - 1), 3'd1, 1'b0}); end
    end
    step(0, 8'h00, 0, 1, 0);
    checks++; if ({upd_index, occupancy} !== {8'h8A, 3'd0}) begin fails++; $display("FAIL wrap_last: got %h exp 450", {upd_index, occupancy}); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) step(1, 8'hA0 + 8'(i), 1, 0, 0);
    step(0, 8'h00, 0, 1, 1);
    checks++; if ({occupancy, upd_valid} !== {3'd3, 1'b1}) begin fails++; $display("FAIL rmid_pre: got %h exp 7", {occupancy, upd_valid}); end
    #2 rst_n = 0;
    #1;
    checks++; if ({occupancy, pred_ready, res_ready} !== {3'd0, 1'b1, 1'b0}) begin fails++; $display("FAIL rmid_occ: got %h exp 2", {occupancy, pred_ready, res_ready}); end
    checks++; if ({upd_valid, upd_index, upd_taken, mispredict, mcount} !== 27'd0) begin fails++; $display("FAIL rmid_upd: got %h exp 0", {upd_valid, upd_index, upd_taken, mispredict, mcount}); end
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_random();
    bit pv, pt, rv, rt;
    logic [7:0] pi;
    for (int n = 0; n < 400; n++) begin
      pv = 1'($urandom_range(0, 1));
      pi = 8'($urandom);
      pt = 1'($urandom_range(0, 1));
      rv = ($urandom_range(0, 9) < 4);
      rt = (mq.size() > 0 && $urandom_range(0, 9) < 8) ? mq[0][0] : 1'($urandom_range(0, 1));
      step(pv, pi, pt, rv, rt);
      checks++; if (occupancy !== 3'(mq.size())) begin fails++; $display("FAIL rnd_occ@%0d: got %0d exp %0d", n, occupancy, mq.size()); end
      checks++; if ({pred_ready, res_ready} !== {mq.size() != 4, mq.size() != 0}) begin fails++; $display("FAIL rnd_rdy@%0d: got %b exp %b", n, {pred_ready, res_ready}, {mq.size() != 4, mq.size() != 0}); end
      checks++; if ({upd_valid, upd_index, upd_taken} !== {e_uv, e_ui, e_ut}) begin fails++; $display("FAIL rnd_upd@%0d: got %h exp %h", n, {upd_valid, upd_index, upd_taken}, {e_uv, e_ui, e_ut}); end
      checks++; if (mispredict !== e_mis) begin fails++; $display("FAIL rnd_mis@%0d: got %b exp %b", n, mispredict, e_mis); end
      checks++; if (mcount !== 16'((mis_total > 65535) ? 65535 : mis_total)) begin fails++; $display("FAIL rnd_cnt@%0d: got %0d exp %0d", n, mcount, mis_total); end
      checks++; if (mcount2 !== 2'((mis_total > 3) ? 3 : mis_total)) begin fails++; $display("FAIL rnd_cnt2@%0d: got %0d exp %0d", n, mcount2, mis_total); end
    end
  endtask

  initial begin
    test_reset();
    test_training();
    test_flush();
    test_full();
    test_simultaneous();
    test_saturation_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
